// File: rtl/sccb_slave.sv
// SCCB register-access slave: oversamples scl/sda on clk, decodes the device ID
// and sub-address, then runs auto-incrementing burst writes or burst reads.
module sccb_slave #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h42,
  parameter int         DATA_WIDTH     = 8,
  parameter int         ADDR_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_we,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  busy,
  output logic                  done
);
  localparam int SHW = (DATA_WIDTH > ADDR_WIDTH) ? ((DATA_WIDTH > 8) ? DATA_WIDTH : 8)
                                                 : ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8);
  localparam int CW  = $clog2(SHW + 1);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, SUB_ADDR, SUB_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t                state, state_n;
  logic [2:0]            scl_q, sda_q;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [SHW-1:0]        shift, shift_n, rx_word;
  logic                  sda_oe, sda_oe_n;
  logic                  rw, rw_n, ack_on, ack_on_n, acked, acked_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic                  we_n, busy_n, done_n;
  logic                  scl_rise, scl_fall, start, stop;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // [1] is the synchronized level, [2] the delayed copy used for edge detection
  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = ~sda_q[1] & sda_q[2] & scl_q[1];
  assign stop     = sda_q[1] & ~sda_q[2] & scl_q[1];
  assign rx_word  = {shift[SHW-2:0], sda_q[1]};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      sda_oe    <= 1'b0;
      rw        <= 1'b0;
      ack_on    <= 1'b0;
      acked     <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      sda_oe    <= sda_oe_n;
      rw        <= rw_n;
      ack_on    <= ack_on_n;
      acked     <= acked_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_we    <= we_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    sda_oe_n  = sda_oe;
    rw_n      = rw;
    ack_on_n  = ack_on;
    acked_n   = acked;
    addr_n    = reg_addr;
    wdata_n   = reg_wdata;
    we_n      = 1'b0;
    busy_n    = busy;
    done_n    = 1'b0;
    if (start) begin
      state_n   = DEV_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      ack_on_n  = 1'b0;
      busy_n    = 1'b1;
    end else if (stop) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
      done_n   = acked;
      acked_n  = 1'b0;
    end else begin
      case (state)
        DEV_ADDR: if (scl_rise) begin
          shift_n   = rx_word;
          bit_cnt_n = bit_cnt + CW'(1);
          if (bit_cnt == CW'(7)) begin
            if (rx_word[7:1] == DEVICE_ADDRESS) begin
              state_n  = DEV_ACK;
              rw_n     = rx_word[0];
              acked_n  = 1'b1;
              ack_on_n = 1'b0;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        // ACK window spans two scl falls: first one pulls sda low, second one ends it
        DEV_ACK: if (scl_fall) begin
          if (!ack_on) begin
            sda_oe_n = 1'b1;
            ack_on_n = 1'b1;
          end else begin
            ack_on_n  = 1'b0;
            bit_cnt_n = '0;
            if (rw) begin
              state_n  = RD_DATA;
              shift_n  = SHW'(reg_rdata);
              sda_oe_n = ~reg_rdata[DATA_WIDTH-1];
            end else begin
              state_n  = SUB_ADDR;
              sda_oe_n = 1'b0;
            end
          end
        end
        SUB_ADDR: if (scl_rise) begin
          shift_n   = rx_word;
          bit_cnt_n = bit_cnt + CW'(1);
          if (bit_cnt == CW'(ADDR_WIDTH - 1)) begin
            addr_n   = rx_word[ADDR_WIDTH-1:0];
            state_n  = SUB_ACK;
            ack_on_n = 1'b0;
          end
        end
        SUB_ACK: if (scl_fall) begin
          if (!ack_on) begin
            sda_oe_n = 1'b1;
            ack_on_n = 1'b1;
          end else begin
            sda_oe_n  = 1'b0;
            ack_on_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = WR_DATA;
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_n   = rx_word;
          bit_cnt_n = bit_cnt + CW'(1);
          if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
            wdata_n  = rx_word[DATA_WIDTH-1:0];
            we_n     = 1'b1;
            state_n  = WR_ACK;
            ack_on_n = 1'b0;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!ack_on) begin
            sda_oe_n = 1'b1;
            ack_on_n = 1'b1;
          end else begin
            sda_oe_n  = 1'b0;
            ack_on_n  = 1'b0;
            bit_cnt_n = '0;
            addr_n    = reg_addr + ADDR_WIDTH'(1);
            state_n   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise) bit_cnt_n = bit_cnt + CW'(1);
          if (scl_fall) begin
            if (bit_cnt == CW'(DATA_WIDTH)) begin
              sda_oe_n = 1'b0;
              state_n  = RD_ACK;
            end else begin
              shift_n  = shift << 1;
              sda_oe_n = ~shift_n[DATA_WIDTH-1];
            end
          end
        end
        // address advances on the ACK rise so reg_rdata is settled by the reload fall
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_q[1]) begin
              addr_n   = reg_addr + ADDR_WIDTH'(1);
              ack_on_n = 1'b1;
            end else begin
              state_n = WAIT_STOP;
            end
          end else if (scl_fall && ack_on) begin
            ack_on_n  = 1'b0;
            bit_cnt_n = '0;
            shift_n   = SHW'(reg_rdata);
            sda_oe_n  = ~reg_rdata[DATA_WIDTH-1];
            state_n   = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sccb_slave.sv
// Bus-level master driving sccb_slave against a register-bank model.
module tb_sccb_slave;
  localparam logic [6:0] DEV = 7'h42;

  logic       clk = 1'b0, rstn = 1'b0, scl = 1'b1, m_low = 1'b0;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, busy, done;

  logic [7:0]  bank [256];
  logic [7:0]  mdl  [256];
  logic [7:0]  ptr = 8'h00;
  logic [7:0]  dq [$];
  logic [15:0] we_log [$];
  logic [15:0] wexp [$];
  int          n_vec = 0, n_err = 0, done_cnt = 0, exp_done = 0, we_chk = 0;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  assign reg_rdata = bank[reg_addr];
  always #5 clk = ~clk;

  sccb_slave #(.DEVICE_ADDRESS(DEV), .DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .scl(scl), .sda(sda),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .busy(busy), .done(done)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // register bank and event log
  initial begin
    for (int i = 0; i < 256; i++) bank[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (reg_we) begin
        we_log.push_back({reg_addr, reg_wdata});
        bank[reg_addr] = reg_wdata;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one bit: sda set mid-low, sampled mid-high
  task automatic bus_bit(input logic b, output logic rd);
    wait_n(4); m_low = ~b;
    wait_n(4); scl = 1'b1;
    wait_n(4); rd = sda;
    wait_n(4); scl = 1'b0;
  endtask

  task automatic bus_start;
    wait_n(4); m_low = 1'b0;
    wait_n(4); scl = 1'b1;
    wait_n(8); m_low = 1'b1;
    wait_n(8); scl = 1'b0;
  endtask

  task automatic bus_stop;
    wait_n(4); m_low = 1'b1;
    wait_n(4); scl = 1'b1;
    wait_n(8); m_low = 1'b0;
    wait_n(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic rd;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], rd);
    bus_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic rd;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, rd);
      d[i] = rd;
    end
    bus_bit(~mack, rd);
  endtask

  task automatic check_side;
    chk("we_count", we_log.size(), wexp.size());
    for (int i = we_chk; i < wexp.size() && i < we_log.size(); i++)
      chk("we_addr_data", we_log[i], wexp[i]);
    we_chk = wexp.size();
    chk("done_count", done_cnt, exp_done);
    chk("busy_idle", busy, 1'b0);
    chk("reg_addr", reg_addr, ptr);
  endtask

  // write: sub-address then the bytes in dq
  task automatic do_write(input logic [6:0] id, input logic [7:0] sub);
    logic ack;
    logic ok;
    logic [7:0] a;
    ok = (id == DEV);
    bus_start;
    chk("busy_start", busy, 1'b1);
    send_byte({id, 1'b0}, ack);
    chk("dev_ack_w", ack, ok ? 1'b0 : 1'b1);
    send_byte(sub, ack);
    chk("sub_ack", ack, ok ? 1'b0 : 1'b1);
    foreach (dq[i]) begin
      send_byte(dq[i], ack);
      chk("data_ack", ack, ok ? 1'b0 : 1'b1);
      if (ok) begin
        a = sub + 8'(i);
        wexp.push_back({a, dq[i]});
        mdl[a] = dq[i];
      end
    end
    if (ok) begin
      ptr = sub + 8'(dq.size());
      exp_done++;
    end
    bus_stop;
    check_side();
  endtask

  // read n bytes; optionally set the sub-address first (via STOP/START or repeated START)
  task automatic do_read(input logic [6:0] id, input logic has_sub, input logic [7:0] sub,
                         input logic use_sr, input int n);
    logic ack;
    logic ok;
    logic [7:0] d;
    ok = (id == DEV);
    if (has_sub) begin
      bus_start;
      send_byte({DEV, 1'b0}, ack);
      chk("rd_setup_ack", ack, 1'b0);
      send_byte(sub, ack);
      chk("rd_sub_ack", ack, 1'b0);
      ptr = sub;
      if (!use_sr) begin
        bus_stop;
        exp_done++;
      end
    end
    bus_start;
    send_byte({id, 1'b1}, ack);
    chk("dev_ack_r", ack, ok ? 1'b0 : 1'b1);
    if (ok) begin
      for (int k = 0; k < n; k++) begin
        recv_byte(k != n - 1, d);
        chk("rd_data", d, mdl[ptr]);
        if (k != n - 1) ptr = ptr + 8'd1;
      end
      exp_done++;
    end else begin
      recv_byte(1'b0, d);
      chk("rd_released", d, 8'hFF);
    end
    bus_stop;
    check_side();
  endtask

  function automatic logic [6:0] pick_id();
    logic [6:0] r;
    r = DEV;
    if ($urandom_range(0, 3) == 0) begin
      r = 7'($urandom);
      if (r == DEV) r = r ^ 7'h01;
    end
    return r;
  endfunction

  initial begin
    logic ack;
    logic sr;
    int kind;
    int n;
    for (int i = 0; i < 256; i++) mdl[i] = init_val(i);
    wait_n(4);
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", reg_we, 1'b0);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    rstn = 1'b1;
    wait_n(4);

    dq.delete(); dq.push_back(8'h5A);
    do_write(DEV, 8'h12);
    dq.delete(); dq.push_back(8'hC3);
    do_write(DEV, 8'h0A);
    do_read(DEV, 1'b1, 8'h0A, 1'b0, 1);
    dq.delete(); dq.push_back(8'h77);
    do_write(7'h48, 8'h33);
    dq.delete(); dq.push_back(8'h11); dq.push_back(8'h22);
    do_write(DEV, 8'hFF);
    do_read(DEV, 1'b1, 8'h20, 1'b1, 2);

    // reset while the slave is driving a 0 data bit
    dq.delete(); dq.push_back(8'h3C);
    do_write(DEV, 8'h40);
    bus_start;
    send_byte({DEV, 1'b0}, ack);
    send_byte(8'h40, ack);
    bus_start;
    send_byte({DEV, 1'b1}, ack);
    chk("mid_dev_ack", ack, 1'b0);
    wait_n(6);
    chk("mid_sda_low", sda, 1'b0);
    rstn = 1'b0;
    wait_n(1);
    chk("mid_sda_rel", sda, 1'b1);
    chk("mid_busy", busy, 1'b0);
    rstn = 1'b1;
    ptr = 8'h00;
    bus_stop;
    check_side();

    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        dq.delete();
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) dq.push_back(8'($urandom));
        do_write(pick_id(), 8'($urandom));
      end else if (kind == 1) begin
        sr = 1'($urandom);
        do_read(sr ? DEV : pick_id(), 1'b1, 8'($urandom), sr, $urandom_range(1, 3));
      end else begin
        do_read(DEV, 1'b0, 8'h00, 1'b0, $urandom_range(1, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sccb_slave.md
SCCB_SLAVE -- requirements
Module: sccb_slave

Interface
REQ-001 Parameter DEVICE_ADDRESS, default 7'h42, 7-bit SCCB device ID this block answers to.
REQ-002 Parameter DATA_WIDTH, default 8, register data width; ADDR_WIDTH, default 8, sub-address width.
REQ-003 clk  input  1  single block clock; all logic on posedge clk.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 scl  input  1  SCCB clock from master, asynchronous to clk.
REQ-006 sda  inout  1  SCCB data; open-drain: block drives 0 or high-Z, never drives 1.
REQ-007 reg_addr  output  ADDR_WIDTH  current register sub-address.
REQ-008 reg_wdata  output  DATA_WIDTH  write data, valid while reg_we=1.
REQ-009 reg_we  output  1  one-cycle write strobe.
REQ-010 reg_rdata  input  DATA_WIDTH  read data for reg_addr, combinational from register bank.
REQ-011 busy  output  1  high from START detection until STOP detection.
REQ-012 done  output  1  one-cycle pulse at STOP ending a transaction whose device address was ACKed.

Function
REQ-013 scl and sda input SHALL each pass a 2-flop synchronizer; edges detected against a third registered copy.
REQ-014 START = synchronized sda falling while synchronized scl high; STOP = sda rising while scl high; both SHALL override any state.
REQ-015 START (incl. repeated START) -> DEV_ADDR, bit counter cleared, sda released, busy=1.
REQ-016 STOP -> IDLE, sda released, busy=0; done pulses 1 cycle if device address had been ACKed.
REQ-017 States: IDLE, DEV_ADDR, DEV_ACK, SUB_ADDR, SUB_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-018 Receive bits SHALL be sampled on scl rising edge, MSB first; sda output changes only on scl falling edge.
REQ-019 DEV_ADDR: after 8th bit, if bits[7:1]==DEVICE_ADDRESS -> DEV_ACK, latch R/W bit; else -> WAIT_STOP, no ACK.
REQ-020 ACK states: drive sda=0 from scl falling edge after 8th bit to scl falling edge after 9th bit, then release.
REQ-021 DEV_ACK exit: R/W=0 -> SUB_ADDR; R/W=1 -> RD_DATA, first bit driven at same scl fall that ends ACK.
REQ-022 SUB_ADDR: 8 bits -> reg_addr updated at 8th rising edge; SUB_ACK -> WR_DATA.
REQ-023 WR_DATA: after 8th bit, reg_wdata=byte, reg_we=1 for exactly one cycle with current reg_addr; WR_ACK -> WR_DATA, reg_addr+1.
REQ-024 reg_addr increment SHALL wrap 8'hFF -> 8'h00.
REQ-025 RD_DATA: reg_rdata sampled into shift register at the scl falling edge entering RD_DATA; 8 bits shifted MSB first; sda released for '1', driven 0 for '0'.
REQ-026 RD_ACK: sda released; master bit sampled on scl rise; 0 (ACK) -> reg_addr+1, reload, RD_DATA; 1 (NACK) -> WAIT_STOP.
REQ-027 Repeated START after SUB_ACK SHALL keep reg_addr; subsequent read returns that register.
REQ-028 WAIT_STOP: sda released, ignore bits until START or STOP.
REQ-029 Each scl high and low phase SHALL be >= 4 clk cycles; shorter phases are out of spec.
REQ-030 reg_we never asserted in a read, a NACKed address, or on a partial byte cut by START/STOP.

Reset
REQ-031 rstn=0 at posedge clk: state IDLE, sda released, reg_addr=0, reg_wdata=0, reg_we=0, busy=0, done=0, counters and synchronizers cleared (scl/sda sync to 1).
REQ-032 Reset mid-transaction SHALL release sda within one clk; block resumes only on next START.

Verification
REQ-033 Write: START,0x84,0x12,0x5A,STOP -> three ACKs low, reg_we one pulse with reg_addr=0x12, reg_wdata=0x5A, done pulse.
REQ-034 Read: START,0x84,0x0A,STOP,START,0x85, bank[0x0A]=0xC3, master NACK, STOP -> sda carries 1100_0011, reg_we never set, done pulse.
REQ-035 Wrong ID: START,0x90,... -> 9th bit sda high (no ACK), WAIT_STOP, no reg_we, no done.
REQ-036 Burst write at 0xFF: START,0x84,0xFF,0x11,0x22,STOP -> writes 0xFF<=0x11 then 0x00<=0x22.
REQ-037 Repeated START in read: START,0x84,0x20,Sr,0x85, master ACK then NACK -> bytes bank[0x20], bank[0x21] returned.
REQ-038 rstn low during RD_DATA driving 0 -> sda high-Z next cycle, busy=0, no done.
